// File: rtl/snake_engine_if.sv
// Bus between the snake core and its neighbours: move/apple/pixel inputs and
// game status plus colour outputs. The engine uses the slave side.
interface snake_engine_if #(
  parameter int CW = 6
);
  logic [2:0]    i_move;
  logic [CW-1:0] i_apple_cx;
  logic [CW-1:0] i_apple_cy;
  logic [9:0]    i_x;
  logic [9:0]    i_y;
  logic          o_lose;
  logic          o_ate;
  logic [7:0]    o_score;
  logic [CW-1:0] o_head_cx;
  logic [CW-1:0] o_head_cy;
  logic [3:0]    o_r;
  logic [3:0]    o_g;
  logic [3:0]    o_b;

  modport slave (
    input  i_move, i_apple_cx, i_apple_cy, i_x, i_y,
    output o_lose, o_ate, o_score, o_head_cx, o_head_cy, o_r, o_g, o_b
  );

  modport master (
    output i_move, i_apple_cx, i_apple_cy, i_x, i_y,
    input  o_lose, o_ate, o_score, o_head_cx, o_head_cy, o_r, o_g, o_b
  );
endinterface

// File: rtl/snake_engine.sv
// Snake game core: steps head/body once per divided tick, detects wall, self
// and apple collisions, tracks length/score and renders a registered pixel.
//
// state  | meaning
// S_IDLE | waiting for the first direction code
// S_RUN  | stepping once per tick (pause codes skip a step)
// S_DEAD | fatal collision seen; frozen until rst
module snake_engine #(
  parameter int CELL     = 20,
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int MAX_LEN  = 16,
  parameter int TICK_DIV = 12_500_000,
  parameter int WRAP     = 0,
  parameter int START_X  = 2,
  parameter int START_Y  = 0,
  parameter int CW       = 6
) (
  input  logic          clk,
  input  logic          rst,
  snake_engine_if.slave bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] X_LAST    = CW'(GRID_W - 1);
  localparam logic [CW-1:0] Y_LAST    = CW'(GRID_H - 1);
  localparam logic [31:0]   CELL_U    = 32'(CELL);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_run;
  logic          w_dead;

  logic [TW-1:0] r_tick;
  logic [1:0]    r_dir;
  logic [CW-1:0] r_hx;
  logic [CW-1:0] r_hy;
  logic [CW-1:0] r_bx [MAX_LEN];
  logic [CW-1:0] r_by [MAX_LEN];
  logic [LW-1:0] r_len;
  logic [7:0]    r_score;
  logic          r_ate;
  logic [11:0]   r_rgb;

  logic          w_tc;
  logic          w_step;
  logic          w_rev;
  logic [1:0]    w_dir;
  logic [CW-1:0] w_nx;
  logic [CW-1:0] w_ny;
  logic          w_wall;
  logic          w_apple_hit;
  logic          w_self;
  logic          w_fatal;
  logic          w_grow;

  logic [31:0]   w_pcx;
  logic [31:0]   w_pcy;
  logic          w_on_apple;
  logic          w_on_head;
  logic          w_on_body;
  logic [11:0]   w_rgb;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!bus.i_move[2]) w_state_nxt = S_RUN;
      S_RUN:   if (w_step && w_fatal) w_state_nxt = S_DEAD;
      S_DEAD:  w_state_nxt = S_DEAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_run  = (r_state == S_RUN);
    w_dead = (r_state == S_DEAD);
  end

  // ---------------- step decision ----------------
  assign w_tc   = (r_tick == TICK_LAST);
  assign w_step = w_run && w_tc && !bus.i_move[2];

  // Reverse codes differ from the current direction only in bit 1.
  assign w_rev = (bus.i_move[1:0] == (r_dir ^ 2'b10));
  assign w_dir = w_rev ? r_dir : bus.i_move[1:0];

  always_comb begin
    w_nx   = r_hx;
    w_ny   = r_hy;
    w_wall = 1'b0;
    case (w_dir)
      2'd0: begin
        if (r_hx == X_LAST) begin
          w_nx   = '0;
          w_wall = (WRAP == 0);
        end else begin
          w_nx = r_hx + CW'(1);
        end
      end
      2'd1: begin
        if (r_hy == '0) begin
          w_ny   = Y_LAST;
          w_wall = (WRAP == 0);
        end else begin
          w_ny = r_hy - CW'(1);
        end
      end
      2'd2: begin
        if (r_hx == '0) begin
          w_nx   = X_LAST;
          w_wall = (WRAP == 0);
        end else begin
          w_nx = r_hx - CW'(1);
        end
      end
      default: begin
        if (r_hy == Y_LAST) begin
          w_ny   = '0;
          w_wall = (WRAP == 0);
        end else begin
          w_ny = r_hy + CW'(1);
        end
      end
    endcase
  end

  assign w_apple_hit = (w_nx == bus.i_apple_cx) && (w_ny == bus.i_apple_cy) && !w_wall;

  // The tail cell is free to enter unless this step grows the snake.
  always_comb begin
    w_self = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < r_len) && (r_bx[i] == w_nx) && (r_by[i] == w_ny) &&
          !((LW'(i) == (r_len - LW'(1))) && !w_apple_hit))
        w_self = 1'b1;
    end
  end

  assign w_fatal = w_wall || w_self;
  assign w_grow  = w_apple_hit && !w_fatal;

  // ---------------- game state ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick  <= '0;
      r_dir   <= 2'd0;
      r_hx    <= CW'(START_X);
      r_hy    <= CW'(START_Y);
      for (int i = 0; i < MAX_LEN; i++) begin
        r_bx[i] <= '0;
        r_by[i] <= '0;
      end
      r_bx[0] <= CW'(START_X - 1);
      r_by[0] <= CW'(START_Y);
      r_bx[1] <= CW'(START_X - 2);
      r_by[1] <= CW'(START_Y);
      r_len   <= LW'(2);
      r_score <= 8'd0;
      r_ate   <= 1'b0;
    end else begin
      r_tick <= w_tc ? '0 : r_tick + TW'(1);
      r_ate  <= 1'b0;
      if (w_step && !w_fatal) begin
        r_dir   <= w_dir;
        r_hx    <= w_nx;
        r_hy    <= w_ny;
        r_bx[0] <= r_hx;
        r_by[0] <= r_hy;
        for (int i = 1; i < MAX_LEN; i++) begin
          r_bx[i] <= r_bx[i-1];
          r_by[i] <= r_by[i-1];
        end
        if (w_grow) begin
          if (r_len != LW'(MAX_LEN)) r_len <= r_len + LW'(1);
          if (r_score != 8'hFF)      r_score <= r_score + 8'd1;
          r_ate <= 1'b1;
        end
      end
    end
  end

  // ---------------- pixel rendering ----------------
  // Integer division by CELL gives the same cell as the [c*CELL, c*CELL+CELL) test.
  assign w_pcx = 32'(bus.i_x) / CELL_U;
  assign w_pcy = 32'(bus.i_y) / CELL_U;

  assign w_on_apple = (32'(bus.i_apple_cx) == w_pcx) && (32'(bus.i_apple_cy) == w_pcy);
  assign w_on_head  = (32'(r_hx) == w_pcx) && (32'(r_hy) == w_pcy);

  always_comb begin
    w_on_body = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < r_len) && (32'(r_bx[i]) == w_pcx) && (32'(r_by[i]) == w_pcy))
        w_on_body = 1'b1;
    end
  end

  always_comb begin
    w_rgb = 12'h000;
    if (w_on_apple)     w_rgb = 12'hF00;
    else if (w_on_head) w_rgb = w_dead ? 12'h888 : 12'hB48;
    else if (w_on_body) w_rgb = w_dead ? 12'h888 : 12'hB42;
  end

  always_ff @(posedge clk) begin
    if (rst) r_rgb <= 12'h000;
    else     r_rgb <= w_rgb;
  end

  assign bus.o_lose    = w_dead;
  assign bus.o_ate     = r_ate;
  assign bus.o_score   = r_score;
  assign bus.o_head_cx = r_hx;
  assign bus.o_head_cy = r_hy;
  assign bus.o_r       = r_rgb[11:8];
  assign bus.o_g       = r_rgb[7:4];
  assign bus.o_b       = r_rgb[3:0];

endmodule

// File: doc/snake_engine.md
# snake_engine

Parametrised snake game core for the VGA snake design. It holds the snake's head and a body shift register in grid-cell coordinates, and steps the snake once per divided game tick. It detects wall, self and apple collisions, tracks length and score, and renders a registered RGB pixel for the VGA timing block's current (x, y). It sits between the move decoder / apple generator and the VGA output. It adds several things the single-length fixed mover lacked: configurable grid, cell size, maximum length and tick rate, a wall-wrap mode, reverse-move rejection, pause, and a lose state.

## Interface
Parameters:
- CELL, 20, cell edge in pixels
- GRID_W, 32, grid width in cells
- GRID_H, 24, grid height in cells
- MAX_LEN, 16, maximum body segments, excluding the head (≥2)
- TICK_DIV, 12_500_000, clk cycles per game step (≥2)
- WRAP, 0, 1 = edges wrap around; 0 = wall hit sets lose
- START_X, 2, head reset cell x; START_Y, 0, head reset cell y
- CW, 6, cell coordinate width (2^CW ≥ max(GRID_W, GRID_H))

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- move  in  3  000 right(+x), 001 up(−y), 010 left(−x), 011 down(+y), 100–111 pause
- apple_cx, apple_cy  in  CW each  apple cell, sampled at each step
- x, y  in  10 each  current pixel
- lose  out  1  high while in DEAD
- ate  out  1  one-cycle pulse on the step that eats the apple
- score  out  8  apples eaten, saturates at 255
- head_cx, head_cy  out  CW each  current head cell
- r, g, b  out  4 each  pixel colour

## Operation
- Reset values: head = (START_X, START_Y); body[0] = (START_X−1, START_Y); body[1] = (START_X−2, START_Y); other body entries 0; len = 2; dir = right; state IDLE; tick counter 0; score 0; lose 0; ate 0; rgb 0.
- FSM:
  - IDLE → RUN on the first cycle move ∈ {000..011}.
  - RUN → DEAD on a fatal step.
  - DEAD holds until rst. In DEAD no steps occur and move is ignored.
- Tick counter: free-runs 0..TICK_DIV−1 in all states and wraps. A step is taken in RUN when the counter is at TICK_DIV−1 and move is not a pause code.
- Direction: move is sampled at the step.
  - A reverse of dir (right↔left, up↔down) is ignored; the current dir is kept.
  - Otherwise dir ← move.
- Next head = head ± 1 on one axis.
  - WRAP=1: x wraps modulo GRID_W and y wraps modulo GRID_H (e.g. x = GRID_W−1 +1 → 0, y = 0 −1 → GRID_H−1).
  - WRAP=0: an out-of-grid next head is fatal.
- grow = (next head == apple) and no fatal condition.
- Self collision: next head equals body[i] for i < len, excluding body[len−1] when grow=0 (the tail vacates). Self collision is fatal.
- On a fatal step: head, body, len and score are unchanged; state → DEAD; lose ← 1.
- On a non-fatal step:
  - body shifts (body[i] ← body[i−1], body[0] ← head); head ← next head.
  - If grow: len ← min(len+1, MAX_LEN); score ← min(score+1, 255); ate pulses.
  - At len = MAX_LEN, eating still scores and pulses ate but does not lengthen.
- Render priority:
  - apple F,0,0
  - head B,4,8
  - active body segment (i < len) B,4,2
  - else 0,0,0
- In DEAD, head and body render 8,8,8.
- Pixel-to-cell test: x ∈ [cx·CELL, cx·CELL+CELL), same for y. Compute with widths large enough that nothing truncates.

## Timing
- r, g, b are registered: 1 clk after (x, y) are presented.
- A step occurs on the clk edge at counter = TICK_DIV−1. Head, body, len, score, lose and ate all update on that same edge.
- ate is high for exactly that one cycle.
- Steps are TICK_DIV cycles apart. Pausing skips a step; the counter is not reset.
- The IDLE→RUN transition does not reset the counter. The first step happens at the next terminal count where move is a direction.
- rst mid-step takes priority: all state returns to reset values on that edge.

## Test plan
- TICK_DIV=4, reset, move=000 held: head (2,0)→(3,0)→(4,0) every 4 clks. body[0] follows (2,0),(3,0); lose stays 0.
- Apple at (3,0), move=000: on the first step, ate pulses 1 cycle, score=1, len=3; body = (2,0),(1,0),(0,0).
- WRAP=0, START (2,0), move=001: the first step is fatal. lose=1, head stays (2,0), and later moves cause no change until rst.
- WRAP=1, head (31,5), dir right: next head is (0,5) with no lose. Head (4,0) moving up goes to (4,23).
- Moving right then move=010 on the next step: the reverse is ignored and head x increments. move=100 for 3 ticks: head is frozen, then resumes.
- Pixel check: x=45, y=5 with head (2,0) → rgb B,4,8 one clk later. An apple at the same cell overrides to F,0,0. Len=MAX_LEN plus an apple: score increments and len stays at MAX_LEN.
